// File: rtl/tile_collision_probe_if.sv
// Handshake and tile-map probe signals between movement logic, the collision
// probe and the tile-map read port.
interface tile_collision_probe_if;
  logic       start;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [9:0] probe_x;
  logic [9:0] probe_y;
  logic [2:0] tile_in;
  logic       busy;
  logic       done;
  logic       hit;
  logic [3:0] hit_mask;

  modport master (
    output start, pos_x, pos_y, tile_in,
    input  probe_x, probe_y, busy, done, hit, hit_mask
  );

  modport slave (
    input  start, pos_x, pos_y, tile_in,
    output probe_x, probe_y, busy, done, hit, hit_mask
  );
endinterface

// File: rtl/tile_collision_probe.sv
// Walks the four sprite bounding-box corners through the tile map, one per
// cycle, and reports which corners land on solid tiles.
//
// state | meaning
// IDLE  | waiting for start; last result held on hit/hit_mask
// PROBE | corner idx on probe_x/probe_y, tile_in sampled at cycle end
// DONE  | one-cycle done pulse, result valid
module tile_collision_probe #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int EMPTY_CODE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  tile_collision_probe_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_e;

  localparam logic [9:0] DX = 10'(SPR_W - 1);
  localparam logic [9:0] DY = 10'(SPR_H - 1);

  state_e     state_q, state_d;
  logic [9:0] x0_q, x0_d;
  logic [9:0] y0_q, y0_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] work_q, work_d;
  logic [3:0] mask_q, mask_d;
  logic [9:0] probe_x_q, probe_x_d;
  logic [9:0] probe_y_q, probe_y_d;
  logic       solid;

  // idx bit0 selects the right edge, bit1 the bottom edge; sums wrap mod 1024
  function automatic logic [19:0] corner(input logic [9:0] x, input logic [9:0] y,
                                         input logic [1:0] k);
    logic [9:0] cx;
    logic [9:0] cy;
    cx = x + (k[0] ? DX : 10'd0);
    cy = y + (k[1] ? DY : 10'd0);
    return {cx, cy};
  endfunction

  assign solid = (bus.tile_in != 3'(EMPTY_CODE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      idx_q     <= '0;
      work_q    <= '0;
      mask_q    <= '0;
      probe_x_q <= '0;
      probe_y_q <= '0;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      idx_q     <= idx_d;
      work_q    <= work_d;
      mask_q    <= mask_d;
      probe_x_q <= probe_x_d;
      probe_y_q <= probe_y_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    idx_d     = idx_q;
    work_d    = work_q;
    mask_d    = mask_q;
    probe_x_d = probe_x_q;
    probe_y_d = probe_y_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          x0_d                   = bus.pos_x;
          y0_d                   = bus.pos_y;
          idx_d                  = 2'd0;
          work_d                 = 4'b0000;
          {probe_x_d, probe_y_d} = corner(bus.pos_x, bus.pos_y, 2'd0);
          state_d                = PROBE;
        end
      end
      PROBE: begin
        work_d[idx_q] = solid;
        idx_d         = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          mask_d  = work_d;
          state_d = DONE;
        end else begin
          {probe_x_d, probe_y_d} = corner(x0_q, y0_q, idx_q + 2'd1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.probe_x  = probe_x_q;
  assign bus.probe_y  = probe_y_q;
  assign bus.busy     = (state_q == PROBE);
  assign bus.done     = (state_q == DONE);
  assign bus.hit_mask = mask_q;
  assign bus.hit      = |mask_q;

endmodule

// File: tb/tb_tile_collision_probe.sv
// Bench for tile_collision_probe: scoreboard of expected probe coordinates and
// corner masks, filled at request time and drained as the DUT produces them.
module tb_tile_collision_probe;

  localparam int SPR = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   mode   = 0;

  logic [19:0] probe_q[$];
  logic [3:0]  result_q[$];

  always #5 clk = ~clk;

  tile_collision_probe_if bus ();

  tile_collision_probe #(.SPR_W(SPR), .SPR_H(SPR), .EMPTY_CODE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Tile map: 640x480 visible area, everything outside reads as code 3.
  function automatic logic [2:0] tile_model(input logic [9:0] x, input logic [9:0] y,
                                            input int m);
    if (x >= 10'd640 || y >= 10'd480) return 3'd3;
    if (m == 1 && x >= 10'd208 && x <= 10'd239 && y >= 10'd99 && y <= 10'd130) return 3'd2;
    if (m == 2 && x < 10'd144) return 3'd3;
    return 3'd0;
  endfunction

  always_comb bus.tile_in = tile_model(bus.probe_x, bus.probe_y, mode);

  task automatic push_request(input logic [9:0] x, input logic [9:0] y);
    logic [9:0] cx;
    logic [9:0] cy;
    logic [3:0] m;
    for (int k = 0; k < 4; k++) begin
      cx = x + (((k & 1) != 0) ? 10'(SPR - 1) : 10'd0);
      cy = y + (((k & 2) != 0) ? 10'(SPR - 1) : 10'd0);
      probe_q.push_back({cx, cy});
      m[k] = (tile_model(cx, cy, mode) != 3'd0);
    end
    result_q.push_back(m);
  endtask

  task automatic issue(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    bus.pos_x = x;
    bus.pos_y = y;
    bus.start = 1'b1;
    push_request(x, y);
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Scoreboard drain
  always @(negedge clk) begin
    logic [19:0] ep;
    logic [3:0]  em;
    if (rst === 1'b0) begin
      if (bus.busy === 1'b1) begin
        checks++;
        if (probe_q.size() == 0) begin
          errors++;
          $display("FAIL probe_unexpected got=(%0d,%0d) expected=none", bus.probe_x, bus.probe_y);
        end else begin
          ep = probe_q.pop_front();
          if ({bus.probe_x, bus.probe_y} !== ep) begin
            errors++;
            $display("FAIL probe_coord got=(%0d,%0d) expected=(%0d,%0d)",
                     bus.probe_x, bus.probe_y, ep[19:10], ep[9:0]);
          end
        end
      end
      if (bus.done === 1'b1) begin
        checks++;
        if (result_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got mask=%b expected=no done", bus.hit_mask);
        end else begin
          em = result_q.pop_front();
          if (bus.hit_mask !== em || bus.hit !== (|em)) begin
            errors++;
            $display("FAIL result got mask=%b hit=%b expected mask=%b hit=%b",
                     bus.hit_mask, bus.hit, em, |em);
          end
        end
      end
    end
  end

  task automatic test_reset();
    int ndone;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.pos_x = 10'd123;
    bus.pos_y = 10'd45;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hit !== 1'b0 || bus.hit_mask !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status got busy=%b done=%b hit=%b mask=%b expected 0 0 0 0000",
               bus.busy, bus.done, bus.hit, bus.hit_mask);
    end
    checks++;
    if (bus.probe_x !== 10'd0 || bus.probe_y !== 10'd0) begin
      errors++;
      $display("FAIL reset_probe got=(%0d,%0d) expected=(0,0)", bus.probe_x, bus.probe_y);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL reset_quiet got activity_cycles=%0d expected=0", ndone);
    end
  endtask

  task automatic test_clear_move();
    int n;
    mode = 0;
    issue(10'd176, 10'd67);
    wait_done(n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL clear_latency got=%0d expected=5", n);
    end
    checks++;
    if (bus.hit_mask !== 4'b0000 || bus.hit !== 1'b0) begin
      errors++;
      $display("FAIL clear_result got mask=%b hit=%b expected 0000 0", bus.hit_mask, bus.hit);
    end
    checks++;
    if (probe_q.size() != 0) begin
      errors++;
      $display("FAIL clear_probe_count got leftover=%0d expected=0", probe_q.size());
    end
  endtask

  task automatic test_single_corner();
    int n;
    mode = 1;
    issue(10'd200, 10'd90);
    wait_done(n);
    checks++;
    if (n != 5 || bus.hit_mask !== 4'b1000 || bus.hit !== 1'b1) begin
      errors++;
      $display("FAIL single_result got lat=%0d mask=%b hit=%b expected 5 1000 1",
               n, bus.hit_mask, bus.hit);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.hit_mask !== 4'b1000 || bus.hit !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_hold got mask=%b hit=%b done=%b busy=%b expected 1000 1 0 0",
               bus.hit_mask, bus.hit, bus.done, bus.busy);
    end
    checks++;
    if (bus.probe_x !== 10'd231 || bus.probe_y !== 10'd121) begin
      errors++;
      $display("FAIL single_probe_hold got=(%0d,%0d) expected=(231,121)", bus.probe_x, bus.probe_y);
    end
  endtask

  task automatic test_off_map();
    int n;
    mode = 2;
    issue(10'd1010, 10'd35);
    wait_done(n);
    checks++;
    if (n != 5 || bus.hit_mask !== 4'b1111 || bus.hit !== 1'b1) begin
      errors++;
      $display("FAIL offmap_result got lat=%0d mask=%b hit=%b expected 5 1111 1",
               n, bus.hit_mask, bus.hit);
    end
  endtask

  task automatic test_busy_ignore();
    logic exp_busy;
    logic exp_done;
    mode = 2;
    @(negedge clk);
    bus.pos_x = 10'd1010;
    bus.pos_y = 10'd35;
    bus.start = 1'b1;
    push_request(10'd1010, 10'd35);
    push_request(10'd1010, 10'd35);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 8) bus.start = 1'b0;
      exp_done = (c == 5) || (c == 11);
      exp_busy = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      checks++;
      if (bus.done !== exp_done || bus.busy !== exp_busy) begin
        errors++;
        $display("FAIL busy_ignore_cycle%0d got busy=%b done=%b expected busy=%b done=%b",
                 c, bus.busy, bus.done, exp_busy, exp_done);
      end
    end
    checks++;
    if (probe_q.size() != 0 || result_q.size() != 0) begin
      errors++;
      $display("FAIL busy_ignore_drain got probes=%0d results=%0d expected 0 0",
               probe_q.size(), result_q.size());
    end
  endtask

  task automatic test_reset_mid_probe();
    int ndone;
    int n;
    mode = 2;
    issue(10'd1010, 10'd35);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.probe_x !== 10'd1010 || bus.probe_y !== 10'd66) begin
      errors++;
      $display("FAIL midrst_pre got busy=%b probe=(%0d,%0d) expected 1 (1010,66)",
               bus.busy, bus.probe_x, bus.probe_y);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    probe_q.delete();
    result_q.delete();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hit_mask !== 4'b0000 || bus.hit !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post got busy=%b done=%b mask=%b hit=%b expected 0 0 0000 0",
               bus.busy, bus.done, bus.hit_mask, bus.hit);
    end
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL midrst_no_done got pulses=%0d expected=0", ndone);
    end
    mode = 1;
    issue(10'd200, 10'd90);
    wait_done(n);
    checks++;
    if (n != 5 || bus.hit_mask !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_recover got lat=%0d mask=%b expected 5 1000", n, bus.hit_mask);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    test_reset();
    test_clear_move();
    test_single_corner();
    test_off_map();
    test_busy_ignore();
    test_reset_mid_probe();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
